// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array edge logic: default widths,
// lane slicing helper and the activation feeder state encoding.
package sa_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_STREAM = 2'd1,
    FS_FLUSH  = 2'd2
  } feed_state_t;

  // LSB position of lane `lane` inside a packed vector of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// DEPTH-stage {valid, data} shift register; shifts every cycle, no stall.
module lane_delay #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data
);

  logic [DEPTH-1:0]  valid_sr;
  logic [DATA_W-1:0] data_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) data_sr[i] <= '0;
    end else begin
      valid_sr[0] <= d_valid;
      data_sr[0]  <= d_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        data_sr[i]  <= data_sr[i-1];
      end
    end
  end

  assign q_valid = valid_sr[DEPTH-1];
  assign q_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Row-edge activation feeder: diagonally skews accepted vectors onto the
// array rows and flushes the skew with zeros after the last vector of a tile.
//
// state     | meaning
// FS_IDLE   | no tile open; ready for a first vector
// FS_STREAM | tile open; accepting vectors, bubbles inject zeros
// FS_FLUSH  | last vector taken; draining skew for ROWS-1 cycles
module act_skew_feeder
  import sa_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*DATA_W-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [ROWS*DATA_W-1:0] out_a,
  output logic [ROWS-1:0]        out_valid,
  output logic                   busy,
  output logic                   tile_done
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((ROWS > 1) ? ROWS - 2 : 0);

  feed_state_t      state, state_next;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_next;
  logic             done_next;
  logic             accept;

  assign s_ready = (state != FS_FLUSH);
  assign busy    = (state != FS_IDLE);
  assign accept  = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FS_IDLE;
      flush_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      tile_done <= done_next;
    end
  end

  // Single-row arrays have no skew to drain, so the last vector closes the tile at once.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    done_next      = 1'b0;
    unique case (state)
      FS_IDLE, FS_STREAM: begin
        if (accept) begin
          if (s_last) begin
            if (ROWS == 1) begin
              state_next = FS_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next     = FS_FLUSH;
              flush_cnt_next = FLUSH_LOAD;
            end
          end else begin
            state_next = FS_STREAM;
          end
        end
      end
      FS_FLUSH: begin
        if (flush_cnt == '0) begin
          state_next = FS_IDLE;
          done_next  = 1'b1;
        end else begin
          flush_cnt_next = flush_cnt - 1'b1;
        end
      end
      default: state_next = FS_IDLE;
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    lane_delay #(
      .DEPTH  (r + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .d_valid (accept),
      .d_data  (accept ? s_data[lane_lsb(r, DATA_W) +: DATA_W] : '0),
      .q_valid (out_valid[r]),
      .q_data  (out_a[lane_lsb(r, DATA_W) +: DATA_W])
    );
  end

endmodule
